// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory port.
package riscv_mem_pkg;

  localparam int unsigned MEM_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane datapath: store lane mask/replication, misalignment, load select/extend.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  req_addr_lo,
  input  mem_size_t   req_size,
  input  logic [31:0] req_wdata,
  output logic [3:0]  byte_en_c,
  output logic [31:0] wdata_rep_c,
  output logic        misaligned_c,
  input  logic [1:0]  rsp_addr_lo,
  input  mem_size_t   rsp_size,
  input  logic        rsp_unsigned,
  input  logic [31:0] rsp_word,
  output logic [31:0] rdata_c
);

  logic [7:0]  byte_sel_c;
  logic [15:0] half_sel_c;

  // Store side: replicate right-aligned data across lanes, enable only the target lanes
  always_comb begin
    byte_en_c    = 4'b0000;
    wdata_rep_c  = req_wdata;
    misaligned_c = 1'b0;
    case (req_size)
      BYTE: begin
        byte_en_c   = 4'b0001 << req_addr_lo;
        wdata_rep_c = {4{req_wdata[7:0]}};
      end
      HALF: begin
        byte_en_c    = req_addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep_c  = {2{req_wdata[15:0]}};
        misaligned_c = req_addr_lo[0];
      end
      WORD: begin
        byte_en_c    = 4'b1111;
        misaligned_c = |req_addr_lo;
      end
      default: ;
    endcase
  end

  // Load side: pick the addressed lane(s) from the registered word, then extend
  always_comb begin
    byte_sel_c = rsp_word[7:0];
    case (rsp_addr_lo)
      2'd1:    byte_sel_c = rsp_word[15:8];
      2'd2:    byte_sel_c = rsp_word[23:16];
      2'd3:    byte_sel_c = rsp_word[31:24];
      default: byte_sel_c = rsp_word[7:0];
    endcase
    half_sel_c = rsp_addr_lo[1] ? rsp_word[31:16] : rsp_word[15:0];
    rdata_c    = '0;
    case (rsp_size)
      BYTE:    rdata_c = {{24{~rsp_unsigned & byte_sel_c[7]}}, byte_sel_c};
      HALF:    rdata_c = {{16{~rsp_unsigned & half_sel_c[15]}}, half_sel_c};
      WORD:    rdata_c = rsp_word;
      default: rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/unified_memory_port.sv
// Unified instruction/data memory with valid/ready handshake, configurable latency
// and fault reporting; one access outstanding at a time.
module unified_memory_port
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_address,
  input  logic        i_req_write,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_writeData,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_readData,
  output logic        o_rsp_fault
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned ADDR_W = IDX_W + 2;
  localparam int unsigned CNT_W  = 4;
  localparam logic [31:0] SPAN   = 32'(MEM_WORD_BYTES * DEPTH_WORDS);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept_c;
  logic [31:0]       offset_c;
  logic [IDX_W-1:0]  idx_c;
  logic              fault_c;
  logic              fault_hold_c;
  logic              ld_hold_c;
  mem_size_t         req_size_c;

  logic [3:0]        byte_en_c;
  logic [31:0]       wdata_rep_c;
  logic              misaligned_c;
  logic [31:0]       ld_data_c;

  logic              fault_q;
  logic              ld_ok_q;
  logic              rd_en_q;
  logic [1:0]        rsp_addr_lo_q;
  mem_size_t         rsp_size_q;
  logic              rsp_unsigned_q;
  logic [31:0]       rd_word_q;

  logic [31:0]       mem_q [DEPTH_WORDS];

  assign req_size_c = mem_size_t'(i_req_size);
  assign accept_c   = (state_q == IDLE) && i_req_valid;
  assign offset_c   = i_req_address - BASE_ADDR;
  assign idx_c      = offset_c[ADDR_W-1:2];
  assign fault_c    = (offset_c >= SPAN) || misaligned_c || (req_size_c == ILLEGAL);

  // Response qualifiers come straight from the request on the accept edge, else from the hold regs
  assign fault_hold_c = accept_c ? fault_c : fault_q;
  assign ld_hold_c    = accept_c ? (!fault_c && !i_req_write) : ld_ok_q;

  mem_lane_align u_align (
    .req_addr_lo  (i_req_address[1:0]),
    .req_size     (req_size_c),
    .req_wdata    (i_req_writeData),
    .byte_en_c    (byte_en_c),
    .wdata_rep_c  (wdata_rep_c),
    .misaligned_c (misaligned_c),
    .rsp_addr_lo  (rsp_addr_lo_q),
    .rsp_size     (rsp_size_q),
    .rsp_unsigned (rsp_unsigned_q),
    .rsp_word     (rd_word_q),
    .rdata_c      (ld_data_c)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, handshake outputs and captured response attributes
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      o_req_ready    <= 1'b1;
      o_rsp_valid    <= 1'b0;
      o_rsp_fault    <= 1'b0;
      rd_en_q        <= 1'b0;
      fault_q        <= 1'b0;
      ld_ok_q        <= 1'b0;
      rsp_addr_lo_q  <= '0;
      rsp_size_q     <= WORD;
      rsp_unsigned_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      o_req_ready <= (state_d == IDLE);
      o_rsp_valid <= (state_d == RESP);
      o_rsp_fault <= (state_d == RESP) && fault_hold_c;
      rd_en_q     <= (state_d == RESP) && ld_hold_c;
      fault_q     <= fault_hold_c;
      ld_ok_q     <= ld_hold_c;
      if (accept_c) begin
        rsp_addr_lo_q  <= i_req_address[1:0];
        rsp_size_q     <= req_size_c;
        rsp_unsigned_q <= i_req_unsigned;
      end
    end
  end

  // RAM array: registered read and byte-lane write, deliberately without reset
  always_ff @(posedge i_clk) begin
    if (accept_c) begin
      rd_word_q <= mem_q[idx_c];
      if (!fault_c && i_req_write) begin
        for (int b = 0; b < MEM_WORD_BYTES; b++) begin
          if (byte_en_c[b]) mem_q[idx_c][8*b +: 8] <= wdata_rep_c[8*b +: 8];
        end
      end
    end
  end

  assign o_rsp_readData = rd_en_q ? ld_data_c : '0;

endmodule

// File: tb/tb_unified_memory_port.sv
// Directed vector bench for unified_memory_port: LATENCY=1 and LATENCY=4 instances.
module tb_unified_memory_port;

  localparam logic [31:0] B4 = 32'h8000_0000;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_f;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] req_address;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;

  logic        valid1, rdy1, rq_rdy1, rsp_valid1, fault1;
  logic [31:0] rdata1;
  logic        valid4, rdy4, rq_rdy4, rsp_valid4, fault4;
  logic [31:0] rdata4;

  int n_vec = 0;
  int n_bad = 0;

  unified_memory_port #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_req_valid(valid1), .o_req_ready(rq_rdy1),
    .i_req_address(req_address), .i_req_write(req_write), .i_req_size(req_size),
    .i_req_unsigned(req_unsigned), .i_req_writeData(req_wdata),
    .o_rsp_valid(rsp_valid1), .i_rsp_ready(rdy1),
    .o_rsp_readData(rdata1), .o_rsp_fault(fault1)
  );

  unified_memory_port #(.DEPTH_WORDS(16), .BASE_ADDR(B4), .LATENCY(4)) u_dut4 (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_req_valid(valid4), .o_req_ready(rq_rdy4),
    .i_req_address(req_address), .i_req_write(req_write), .i_req_size(req_size),
    .i_req_unsigned(req_unsigned), .i_req_writeData(req_wdata),
    .o_rsp_valid(rsp_valid4), .i_rsp_ready(rdy4),
    .o_rsp_readData(rdata4), .o_rsp_fault(fault4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One complete access on DUT d (1 or 4); returns data, fault and observed latency (0 = none)
  task automatic do_access(input int d, input vec_t v, output logic [31:0] rd, output logic f,
                           output int lat);
    bit ok;
    @(negedge clk);
    req_address = v.addr; req_write = v.w; req_size = v.sz;
    req_unsigned = v.u; req_wdata = v.wd;
    if (d == 4) begin valid4 = 1'b1; rdy4 = 1'b1; end
    else        begin valid1 = 1'b1; rdy1 = 1'b1; end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((d == 4) ? rq_rdy4 : rq_rdy1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("req_ready_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    valid1 = 1'b0; valid4 = 1'b0;
    lat = 0; rd = '0; f = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((d == 4) ? rsp_valid4 : rsp_valid1) begin
        lat = i;
        rd  = (d == 4) ? rdata4 : rdata1;
        f   = (d == 4) ? fault4 : fault1;
        break;
      end
    end
  endtask

  task automatic run_vec(input int d, input vec_t v, input int exp_lat, input string tag);
    logic [31:0] rd;
    logic        f;
    int          lat;
    do_access(d, v, rd, f, lat);
    check({tag, "_rdata"}, rd, v.exp_rd);
    check({tag, "_fault"}, 32'(f), 32'(v.exp_f));
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  vec_t        vt  [26];
  vec_t        vt4 [4];
  vec_t        v;
  logic [31:0] model [4];
  logic [31:0] exp_q [$];
  int          got;
  bit          saw_valid;

  initial begin
    rst_n = 1'b1;
    valid1 = 1'b0; valid4 = 1'b0; rdy1 = 1'b0; rdy4 = 1'b0;
    req_address = '0; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_wdata = '0;

    //        w     sz     u     addr           wd             exp_rd         f
    vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 2'b10, 1'b0, 32'h20,       32'h11223344, 32'h0,        1'b0};
    vt[3]  = '{1'b1, 2'b00, 1'b0, 32'h21,       32'hFFFFFF80, 32'h0,        1'b0};
    vt[4]  = '{1'b0, 2'b10, 1'b1, 32'h20,       32'h0,        32'h11228044, 1'b0};
    vt[5]  = '{1'b0, 2'b00, 1'b0, 32'h21,       32'h0,        32'hFFFFFF80, 1'b0};
    vt[6]  = '{1'b0, 2'b00, 1'b1, 32'h21,       32'h0,        32'h00000080, 1'b0};
    vt[7]  = '{1'b0, 2'b01, 1'b0, 32'h22,       32'h0,        32'h00001122, 1'b0};
    vt[8]  = '{1'b0, 2'b10, 1'b0, 32'h22,       32'h0,        32'h0,        1'b1};
    vt[9]  = '{1'b1, 2'b10, 1'b0, 32'h0,        32'h01020304, 32'h0,        1'b0};
    vt[10] = '{1'b1, 2'b10, 1'b0, 32'h100,      32'hCAFEF00D, 32'h0,        1'b1};
    vt[11] = '{1'b0, 2'b10, 1'b0, 32'h0,        32'h0,        32'h01020304, 1'b0};
    vt[12] = '{1'b0, 2'b11, 1'b0, 32'h10,       32'h0,        32'h0,        1'b1};
    vt[13] = '{1'b1, 2'b01, 1'b0, 32'h12,       32'hFFFF8001, 32'h0,        1'b0};
    vt[14] = '{1'b0, 2'b01, 1'b0, 32'h12,       32'h0,        32'hFFFF8001, 1'b0};
    vt[15] = '{1'b0, 2'b01, 1'b1, 32'h12,       32'h0,        32'h00008001, 1'b0};
    vt[16] = '{1'b0, 2'b00, 1'b1, 32'h10,       32'h0,        32'h000000EF, 1'b0};
    vt[17] = '{1'b0, 2'b00, 1'b0, 32'h13,       32'h0,        32'hFFFFFF80, 1'b0};
    vt[18] = '{1'b0, 2'b01, 1'b0, 32'h11,       32'h0,        32'h0,        1'b1};
    vt[19] = '{1'b1, 2'b00, 1'b0, 32'h13,       32'h1234565A, 32'h0,        1'b0};
    vt[20] = '{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        32'h5A01BEEF, 1'b0};
    vt[21] = '{1'b1, 2'b11, 1'b0, 32'h20,       32'hFFFFFFFF, 32'h0,        1'b1};
    vt[22] = '{1'b0, 2'b10, 1'b0, 32'h20,       32'h0,        32'h11228044, 1'b0};
    vt[23] = '{1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1};
    vt[24] = '{1'b1, 2'b01, 1'b0, 32'h1E,       32'h7777ABCD, 32'h0,        1'b0};
    vt[25] = '{1'b0, 2'b01, 1'b1, 32'h1E,       32'h0,        32'h0000ABCD, 1'b0};

    vt4[0] = '{1'b0, 2'b10, 1'b0, 32'h0,        32'h0,        32'h0,        1'b1};
    vt4[1] = '{1'b0, 2'b10, 1'b0, B4 + 32'h40,  32'h0,        32'h0,        1'b1};
    vt4[2] = '{1'b1, 2'b10, 1'b0, B4 + 32'h3C,  32'h0BADF00D, 32'h0,        1'b0};
    vt4[3] = '{1'b0, 2'b10, 1'b0, B4 + 32'h3C,  32'h0,        32'h0BADF00D, 1'b0};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready1", 32'(rq_rdy1), 32'd1);
    check("rst_rsp_valid1", 32'(rsp_valid1), 32'd0);
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_fault1", 32'(fault1), 32'd0);
    check("rst_req_ready4", 32'(rq_rdy4), 32'd1);
    check("rst_rsp_valid4", 32'(rsp_valid4), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) run_vec(1, vt[i], 1, $sformatf("l1_vec%0d", i));

    // Latency 4 with response backpressure
    v = '{1'b1, 2'b10, 1'b0, B4 + 32'h8, 32'h13579BDF, 32'h0, 1'b0};
    run_vec(4, v, 4, "l4_store");
    @(negedge clk);
    req_address = B4 + 32'h8; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    valid4 = 1'b1; rdy4 = 1'b0;
    check("l4_ready_before", 32'(rq_rdy4), 32'd1);
    @(posedge clk);
    #1;
    valid4 = 1'b0; req_address = 32'hFFFF_FFFF; req_write = 1'b1; req_size = 2'b11;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("l4_wait%0d_valid", c), 32'(rsp_valid4), 32'd0);
      check($sformatf("l4_wait%0d_ready", c), 32'(rq_rdy4), 32'd0);
    end
    @(negedge clk);
    check("l4_resp_valid", 32'(rsp_valid4), 32'd1);
    check("l4_resp_rdata", rdata4, 32'h13579BDF);
    check("l4_resp_fault", 32'(fault4), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("l4_stall%0d_valid", c), 32'(rsp_valid4), 32'd1);
      check($sformatf("l4_stall%0d_rdata", c), rdata4, 32'h13579BDF);
      check($sformatf("l4_stall%0d_ready", c), 32'(rq_rdy4), 32'd0);
    end
    rdy4 = 1'b1;
    @(negedge clk);
    check("l4_post_valid", 32'(rsp_valid4), 32'd0);
    check("l4_post_ready", 32'(rq_rdy4), 32'd1);
    check("l4_post_rdata", rdata4, 32'h0);

    // Reset asserted while a store sits in WAIT
    @(negedge clk);
    req_address = B4; req_write = 1'b1; req_size = 2'b10; req_wdata = 32'hA5A5A5A5;
    valid4 = 1'b1; rdy4 = 1'b1;
    @(posedge clk);
    #1 valid4 = 1'b0;
    @(negedge clk);
    check("rst_mid_wait_ready", 32'(rq_rdy4), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(rq_rdy4), 32'd1);
    check("rst_mid_valid", 32'(rsp_valid4), 32'd0);
    check("rst_mid_rdata", rdata4, 32'h0);
    check("rst_mid_fault", 32'(fault4), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw_valid |= rsp_valid4;
    end
    check("rst_mid_no_rsp", 32'(saw_valid), 32'd0);
    v = '{1'b0, 2'b10, 1'b0, B4, 32'h0, 32'hA5A5A5A5, 1'b0};
    run_vec(4, v, 4, "rst_mid_reload");
    v = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11228044, 1'b0};
    run_vec(1, v, 1, "rst_keep_l1");

    for (int i = 0; i < 4; i++) run_vec(4, vt4[i], 4, $sformatf("l4_vec%0d", i));

    // Back-to-back random word accesses against a scoreboard
    got = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          logic [1:0]  idx;
          logic        w;
          logic [31:0] wd;
          bit          ok;
          idx = (i < 4) ? 2'(i) : 2'($urandom_range(0, 3));
          w   = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
          wd  = $urandom;
          @(negedge clk);
          req_address = 32'h80 + 32'(idx) * 4; req_write = w; req_size = 2'b10;
          req_unsigned = 1'($urandom_range(0, 1)); req_wdata = wd; valid1 = 1'b1;
          ok = 1'b0;
          for (int t = 0; t < 50; t++) begin
            if (rq_rdy1) begin ok = 1'b1; break; end
            @(negedge clk);
          end
          check($sformatf("rnd%0d_accept", i), 32'(ok), 32'd1);
          @(posedge clk);
          #1 valid1 = 1'b0;
          if (w) begin
            exp_q.push_back(32'h0);
            model[idx] = wd;
          end else begin
            exp_q.push_back(model[idx]);
          end
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        for (int c = 0; c < 600 && got < 16; c++) begin
          @(negedge clk);
          rdy1 = ($urandom_range(0, 2) != 0);
          if (rsp_valid1 && rdy1) begin
            if (exp_q.size() == 0) begin
              check($sformatf("rnd_extra_rsp%0d", got), 32'd1, 32'd0);
            end else begin
              check($sformatf("rnd_rsp%0d_rdata", got), rdata1, exp_q.pop_front());
              check($sformatf("rnd_rsp%0d_fault", got), 32'(fault1), 32'd0);
            end
            got++;
          end
        end
      end
    join
    rdy1 = 1'b1;
    saw_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_valid |= rsp_valid1 & ~rdy1;
    end
    @(negedge clk);
    saw_valid |= rsp_valid1;
    check("rnd_rsp_count", 32'(got), 32'd16);
    check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
    check("rnd_no_extra", 32'(saw_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/unified_memory_port.md
Name: unified_memory_port

Overview:
- Parametrised unified instruction/data memory for the multi-cycle RISC-V core, replacing the fixed 64-word, word-only, combinational-read memory.
- Adds configurable depth and base address, byte/halfword/word access with byte-lane writes and load sign/zero extension, configurable read latency, and fault reporting.
- Uses a valid/ready request/response handshake with one outstanding access. The core's control FSM waits on `o_rsp_valid` instead of assuming single-cycle memory.

Parameters:
- DEPTH_WORDS, 64: number of 32-bit words; power of two, >= 4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to 4*DEPTH_WORDS.
- LATENCY, 1: cycles from request acceptance to `o_rsp_valid`; integer in 1..8.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_arst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  block can accept a request.
- i_req_address  in  32  byte address.
- i_req_write  in  1  1=store, 0=load/fetch.
- i_req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- i_req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend; ignored for word.
- i_req_writeData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  consumer accepts response.
- o_rsp_readData  out  32  load result, right-aligned and extended; 0 for stores and faults.
- o_rsp_fault  out  1  access was misaligned, out of range, or illegal size.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- **Reset:** state=IDLE, `o_req_ready`=1, `o_rsp_valid`=0, `o_rsp_readData`=0, `o_rsp_fault`=0, latency counter=0.
  - Memory array is not reset; its contents survive reset, including reset asserted mid-access.
- **IDLE:** `o_req_ready`=1. Accept on `i_req_valid && o_req_ready`. At the accept edge:
  - Compute fault, capture response data, perform any store.
  - LATENCY=1 → go to RESP; else → WAIT with counter = LATENCY-1.
- **WAIT:** `o_req_ready`=0. Decrement counter each cycle; when counter reaches 1 → RESP.
- **Response timing:** `o_rsp_valid` rises exactly LATENCY cycles after the accept edge.
- **RESP:** `o_rsp_valid`=1.
  - Data and fault are held stable until `i_rsp_ready` is sampled high.
  - Then → IDLE, `o_rsp_valid`=0, and `o_rsp_readData`/`o_rsp_fault` clear to 0.
  - No new request is accepted in the same cycle as response handoff; back-to-back throughput is one access per LATENCY+1 cycles minimum.
- **Fault conditions:**
  - offset = address - BASE_ADDR; out of range if offset >= 4*DEPTH_WORDS (unsigned, so addresses below BASE_ADDR also fault).
  - Misaligned: half with address[0]=1; word with address[1:0]!=0.
  - Size 11 always faults.
- **Faulting access:** no memory write, readData=0, fault=1; otherwise treated as a normal access, including latency.
- **Stores:** word index = offset[log2(4*DEPTH_WORDS)-1:2].
  - Byte: write lane address[1:0] with writeData[7:0].
  - Half: lanes {address[1],0} and {address[1],1} with writeData[15:0].
  - Word: all four lanes.
  - Other lanes unchanged. Store response carries readData=0, fault=0.
- **Loads:** read the word at the accept edge (registered read, inferable as block RAM), select the lane, then extend.
  - Byte 0x80 signed → 0xFFFF_FF80.
  - Byte 0x80 unsigned → 0x0000_0080.
- **Input sampling:** request inputs are ignored outside the accept edge and may change freely in WAIT and RESP.
- **Asynchronous reset mid-access:** the pending response is dropped. A store accepted at an earlier edge has already completed and is retained.

Decomposition:
- Shared package `riscv_mem_pkg`:
  - enum `mem_size_t` (BYTE, HALF, WORD, ILLEGAL) for `i_req_size`.
  - enum `mem_state_t` (IDLE, WAIT, RESP).
  - Constant `MEM_WORD_BYTES`=4.
- One sub-module, `mem_lane_align` (combinational), holding the datapath:
  - store lane mask and byte-replicated write data;
  - load lane select and sign/zero extension;
  - misalignment flag.
- Top level holds the FSM, latency counter, range check, and the RAM array.

Test Plan:
1. **Word store/load, LATENCY=1:** store word 0xDEADBEEF @0x10, then load word @0x10.
   - `o_rsp_valid` rises 1 cycle after each accept; readData=0xDEADBEEF, fault=0.
2. **Byte/half stores and extending loads:**
   - Store byte 0x80 @0x21 over existing word 0x11223344 → word reads 0x11228044.
   - Load byte signed @0x21 → 0xFFFFFF80; unsigned → 0x00000080.
   - Load half signed @0x22 → 0x00001122.
3. **Faults:**
   - Load word @0x22 → fault=1, readData=0.
   - Store word @0x100 with DEPTH_WORDS=64 → fault=1, memory unchanged.
   - Size 11 → fault=1.
4. **Latency and backpressure, LATENCY=4:**
   - Load accepted at cycle 0 → `o_rsp_valid` at cycle 4.
   - Hold `i_rsp_ready`=0 for 3 cycles: data stable, `o_req_ready`=0 throughout.
   - `o_req_ready` returns 1 the cycle after the handshake.
5. **Reset mid-access:** store 0xA5A5A5A5 @0x0 accepted, then `i_arst_n` low during WAIT.
   - Outputs return to reset values immediately, with no response.
   - After release, load @0x0 → 0xA5A5A5A5.
6. **Back-to-back:** 16 random aligned accesses with random `i_rsp_ready` stalls, compared against a scoreboard model.
   - Exactly one response per accepted request, in order.
